// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the system bus arbiter and related arbiters.
// Contents:
//   arb_state_t       - arbiter FSM states (idle / bus owned)
//   NUM_M_DEFAULT     - default number of bus masters
//   MAX_HOLD_DEFAULT  - default contended-hold limit in bus cycles
//   EN / DIS_EN       - active / inactive levels for grant and busy
package bus_arbiter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_M_DEFAULT    = 4;
  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  localparam logic EN     = 1'b1;
  localparam logic DIS_EN = 1'b0;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index rr_ptr, wrapping modulo NUM, and returns
// the first set index.
// Ports:
//   req    - request vector
//   rr_ptr - index with highest priority for this search
//   winner - index of the selected request (0 when none found)
//   found  - high when any request bit is set
module bus_arbiter_rr_pick #(
  parameter int unsigned NUM   = 4,
  parameter int unsigned IDX_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      idx = IDX_W'((32'(rr_ptr) + 32'(i)) % NUM);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus.
// Grants one master at a time with registered outputs, hands over directly
// between tenures without an idle bubble, preempts an unlocked owner after
// MAX_HOLD contended cycles, and honours the owner's lock for atomic sequences.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   m_req    - per-master request, held for the whole tenure
//   m_lock   - per-master lock; only the current owner's bit is used
//   m_grant  - one-hot registered grant, zero when idle
//   owner    - index of the current owner, valid while bus_busy
//   bus_busy - high while a grant is active
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M    = NUM_M_DEFAULT,
  parameter int unsigned OWN_W    = $clog2(NUM_M),
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_M-1:0] m_req,
  input  logic [NUM_M-1:0] m_lock,
  output logic [NUM_M-1:0] m_grant,
  output logic [OWN_W-1:0] owner,
  output logic             bus_busy
);

  localparam logic [7:0] HoldMax = 8'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic             busy_q, busy_d;
  logic [OWN_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       hold_q, hold_d;

  logic [NUM_M-1:0] others_req;
  logic [NUM_M-1:0] pick_req;
  logic             owner_req;
  logic             owner_lock;
  logic             preempt;
  logic             take;
  logic [OWN_W-1:0] win;
  logic             found;

  // grant_q is the owner's one-hot mask while owned, and zero while idle.
  assign others_req = m_req & ~grant_q;
  assign owner_req  = |(m_req & grant_q);
  assign owner_lock = |(m_lock & grant_q);
  // The current owner never competes for its own handover.
  assign pick_req   = (state_q == StOwned) ? others_req : m_req;
  assign preempt    = !owner_lock && (hold_q == HoldMax) && found;

  bus_arbiter_rr_pick #(
    .NUM   (NUM_M),
    .IDX_W (OWN_W)
  ) u_rr_pick (
    .req    (pick_req),
    .rr_ptr (rr_ptr_q),
    .winner (win),
    .found  (found)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    take     = 1'b0;

    unique case (state_q)
      StIdle: begin
        take = found;
      end
      StOwned: begin
        if (!owner_req) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            busy_d  = DIS_EN;
            hold_d  = '0;
          end
        end else if (preempt) begin
          take = 1'b1;
        end else if (|others_req && (hold_q != HoldMax)) begin
          // Only contended cycles count towards the hold limit.
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (take) begin
      state_d      = StOwned;
      grant_d      = '0;
      grant_d[win] = EN;
      owner_d      = win;
      busy_d       = EN;
      hold_d       = '0;
      rr_ptr_d     = (win == OWN_W'(NUM_M - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      busy_q   <= DIS_EN;
      rr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign m_grant  = grant_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (NUM_M=4, MAX_HOLD=16).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] m_req;
  logic [3:0] m_lock;
  logic [3:0] m_grant;
  logic [1:0] owner;
  logic       bus_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_M    (4),
    .MAX_HOLD (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_lock   (m_lock),
    .m_grant  (m_grant),
    .owner    (owner),
    .bus_busy (bus_busy)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] g;
    int         o;      // -1: owner not checked
    bit         chk_rr;
    logic [1:0] rr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] g, input int o,
                     input bit chk_rr, input logic [1:0] rr);
    vec_t v;
    v.rst    = rst;
    v.req    = req;
    v.g      = g;
    v.o      = o;
    v.chk_rr = chk_rr;
    v.rr     = rr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input int o);
    chk({name, " grant"}, 32'(m_grant), 32'(g));
    chk({name, " busy"}, 32'(bus_busy), 32'(|g));
    chk({name, " onehot0"}, 32'($onehot0(m_grant)), 32'd1);
    if (o >= 0) chk({name, " owner"}, 32'(owner), 32'(o));
  endtask

  initial begin
    reset  = 1'b1;
    m_req  = 4'b0000;
    m_lock = 4'b0000;

    // Reset, single request, release.
    add(1, 4'b0000, 4'b0000, 0, 1, 2'd0);
    add(0, 4'b0010, 4'b0010, 1, 1, 2'd2);
    add(0, 4'b0000, 4'b0000, -1, 0, 2'd0);
    // All masters requesting, 3-cycle tenures, re-request one cycle after release.
    add(1, 4'b0000, 4'b0000, 0, 1, 2'd0);
    add(0, 4'b1111, 4'b0001, 0, 1, 2'd1);
    add(0, 4'b1111, 4'b0001, 0, 0, 2'd0);
    add(0, 4'b1111, 4'b0001, 0, 0, 2'd0);
    add(0, 4'b1110, 4'b0010, 1, 1, 2'd2);
    add(0, 4'b1111, 4'b0010, 1, 0, 2'd0);
    add(0, 4'b1111, 4'b0010, 1, 0, 2'd0);
    add(0, 4'b1101, 4'b0100, 2, 1, 2'd3);
    add(0, 4'b1111, 4'b0100, 2, 0, 2'd0);
    add(0, 4'b1111, 4'b0100, 2, 0, 2'd0);
    add(0, 4'b1011, 4'b1000, 3, 1, 2'd0);
    add(0, 4'b1111, 4'b1000, 3, 0, 2'd0);
    add(0, 4'b1111, 4'b1000, 3, 0, 2'd0);
    add(0, 4'b0111, 4'b0001, 0, 1, 2'd1);
    add(0, 4'b0000, 4'b0000, -1, 0, 2'd0);
    // Owner 3 releases with 0 and 1 pending: wrap to master 0.
    add(1, 4'b0000, 4'b0000, 0, 1, 2'd0);
    add(0, 4'b1000, 4'b1000, 3, 1, 2'd0);
    add(0, 4'b0011, 4'b0001, 0, 1, 2'd1);
    add(0, 4'b0010, 4'b0010, 1, 1, 2'd2);
    // Search from 2 wraps past 3 to reach master 0.
    add(0, 4'b0001, 4'b0001, 0, 1, 2'd1);
    add(0, 4'b0000, 4'b0000, -1, 0, 2'd0);
    // Reset mid-tenure, requests still high.
    add(1, 4'b0000, 4'b0000, 0, 1, 2'd0);
    add(0, 4'b0100, 4'b0100, 2, 1, 2'd3);
    add(0, 4'b0110, 4'b0100, 2, 0, 2'd0);
    add(1, 4'b0110, 4'b0000, 0, 1, 2'd0);
    add(0, 4'b0110, 4'b0010, 1, 1, 2'd2);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      m_req = vecs[i].req;
      step();
      chk_out($sformatf("v%0d", i), vecs[i].g, vecs[i].o);
      if (vecs[i].chk_rr) chk($sformatf("v%0d rr_ptr", i), 32'(dut.rr_ptr_q), 32'(vecs[i].rr));
    end

    // Preemption after 16 contended cycles; a non-owner lock is ignored.
    reset = 1'b1; m_req = 4'b0000; m_lock = 4'b0000;
    step();
    reset = 1'b0; m_req = 4'b0001; m_lock = 4'b0100;
    step();
    chk_out("pre grant0", 4'b0001, 0);
    for (int k = 0; k < 4; k++) step();
    m_req = 4'b0101;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk_out($sformatf("pre hold%0d", k), 4'b0001, 0);
    end
    step();
    chk_out("pre handover", 4'b0100, 2);
    m_req = 4'b0001;
    step();
    chk_out("pre requeue", 4'b0001, 0);

    // Lock held by the owner blocks preemption until it drops.
    reset = 1'b1; m_req = 4'b0000; m_lock = 4'b0000;
    step();
    reset = 1'b0; m_req = 4'b0001; m_lock = 4'b0001;
    step();
    chk_out("lock grant0", 4'b0001, 0);
    for (int k = 0; k < 4; k++) step();
    m_req = 4'b0101;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k % 8 == 0) chk_out($sformatf("lock hold%0d", k), 4'b0001, 0);
      else chk($sformatf("lock hold%0d grant", k), 32'(m_grant), 32'b0001);
    end
    m_lock = 4'b0000;
    step();
    chk_out("lock drop", 4'b0100, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
